// File: rtl/regfile_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_mp_if                                             |
// | Brief    : Bus bundle for the multi-port register file: write,       |
// |            reserve and read-select requests, read data, busy        |
// |            scoreboard and NZP condition codes.                      |
// | Revision : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface regfile_mp_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
);
  logic                           wr_en;
  logic [AW-1:0]                  wr_sel;
  logic [WIDTH-1:0]               wr_data;
  logic                           wr_cc;
  logic                           rsv_en;
  logic [AW-1:0]                  rsv_sel;
  logic [NRD-1:0][AW-1:0]         rd_sel;
  logic [NRD-1:0][WIDTH-1:0]      rd_data;
  logic [NRD-1:0]                 rd_busy;
  logic [DEPTH-1:0]               busy_vec;
  logic [2:0]                     cc_nzp;

  // Decode/writeback side: issues requests, consumes read results
  modport master (
    output wr_en, wr_sel, wr_data, wr_cc, rsv_en, rsv_sel, rd_sel,
    input  rd_data, rd_busy, busy_vec, cc_nzp
  );

  // Register file side
  modport slave (
    input  wr_en, wr_sel, wr_data, wr_cc, rsv_en, rsv_sel, rd_sel,
    output rd_data, rd_busy, busy_vec, cc_nzp
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_mp                                                |
// | Brief    : Parametrised register file, NRD combinational read ports, |
// |            one write port, optional write-to-read bypass, per-      |
// |            register busy scoreboard and NZP condition codes.        |
// | Revision : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module regfile_mp #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 8,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_if.slave    bus
);

  localparam logic [2:0] c_CC_N = 3'b100;
  localparam logic [2:0] c_CC_Z = 3'b010;
  localparam logic [2:0] c_CC_P = 3'b001;

  logic [WIDTH-1:0]          r_regs [DEPTH];
  logic [DEPTH-1:0]          r_busy;
  logic [2:0]                r_cc;

  logic                      w_wr_ok;
  logic                      w_rsv_ok;
  logic                      w_rsv_on_wr;
  logic [NRD-1:0][WIDTH-1:0] w_rd_data;
  logic [NRD-1:0]            w_rd_busy;

  // Indices at or above DEPTH only exist when DEPTH is not a power of two;
  // requests to them must leave all state untouched.
  function automatic logic in_rng(input logic [AW-1:0] idx);
    in_rng = (32'(idx) < 32'(DEPTH));
  endfunction

  // Z has priority because a zero value has a clear sign bit anyway
  function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] d);
    if (d == '0)             cc_of = c_CC_Z;
    else if (d[WIDTH-1])     cc_of = c_CC_N;
    else                     cc_of = c_CC_P;
  endfunction

  assign w_wr_ok     = bus.wr_en  && in_rng(bus.wr_sel);
  assign w_rsv_ok    = bus.rsv_en && in_rng(bus.rsv_sel);
  assign w_rsv_on_wr = w_rsv_ok && (bus.rsv_sel == bus.wr_sel);

  // Register storage: single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
    end else if (w_wr_ok) begin
      for (int k = 0; k < DEPTH; k++)
        if (bus.wr_sel == AW'(k)) r_regs[k] <= bus.wr_data;
    end
  end

  // Busy scoreboard: reserve sets, write clears, reserve wins on a tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rsv_ok && bus.rsv_sel == AW'(k))     r_busy[k] <= 1'b1;
        else if (w_wr_ok && bus.wr_sel == AW'(k))  r_busy[k] <= 1'b0;
      end
    end
  end

  // Condition codes follow qualified writes only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_cc <= c_CC_Z;
    else if (w_wr_ok && bus.wr_cc) r_cc <= cc_of(bus.wr_data);
  end

  // Read ports: registered value, overridden by same-cycle write when bypassing
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.rd_sel[i] == AW'(k)) begin
          w_rd_data[i] = r_regs[k];
          w_rd_busy[i] = r_busy[k];
        end
      end
      if (BYPASS != 0 && !rst && w_wr_ok && bus.wr_sel == bus.rd_sel[i]) begin
        w_rd_data[i] = bus.wr_data;
        w_rd_busy[i] = w_rsv_on_wr;
      end
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.busy_vec = r_busy;
  assign bus.cc_nzp   = r_cc;

endmodule
`default_nettype wire
